// File: rtl/codec_cfg_sequencer.sv
// Command source for the 24-bit two-wire codec serializer: settles after reset, then writes each table entry.
// Build option CODEC_CFG_RETRY_EN: retry failed entries up to MAX_RETRY, else skip them and flag at DONE.
module codec_cfg_sequencer #(
    parameter logic [7:0]  DEV_ADDR     = 8'h34,
    parameter int          LUT_SIZE     = 10,
    parameter logic [15:0] START_DELAY  = 16'd2000,
    parameter int          BUSY_TIMEOUT = 4,
    parameter int          MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    output logic        o_go,
    output logic [23:0] o_data,
    input  logic        i_ready,
    input  logic        i_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [3:0]  o_index,
    output logic [7:0]  o_err_count
);

    typedef enum logic [3:0] {
        S_DELAY,
        S_LOAD,
        S_GO,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CHECK,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, next_state;
    logic [15:0] dly_cnt;
    logic [7:0]  to_cnt;
    logic [7:0]  retry;
    logic [3:0]  idx;
    logic [7:0]  err_count;
    logic        ack_q;
    logic        timeout_q;

    logic delay_hit, busy_hit, failed, retry_ok, last;

    function automatic logic [15:0] table_entry(input logic [3:0] i);
        case (i)
            4'd0:    table_entry = 16'h001A;
            4'd1:    table_entry = 16'h021A;
            4'd2:    table_entry = 16'h047B;
            4'd3:    table_entry = 16'h067B;
            4'd4:    table_entry = 16'h08F8;
            4'd5:    table_entry = 16'h0A06;
            4'd6:    table_entry = 16'h0C00;
            4'd7:    table_entry = 16'h0E01;
            4'd8:    table_entry = 16'h1002;
            4'd9:    table_entry = 16'h1201;
            default: table_entry = 16'h0000;
        endcase
    endfunction

    assign delay_hit = (START_DELAY <= 16'd1) || (dly_cnt == START_DELAY - 16'd1);
    assign busy_hit  = (to_cnt == 8'(BUSY_TIMEOUT - 1));
    assign failed    = ack_q | timeout_q;
    assign retry_ok  = (retry < 8'(MAX_RETRY));
    assign last      = (idx == 4'(LUT_SIZE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_DELAY;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_DELAY:     if (delay_hit) next_state = S_LOAD;
            // never launch into a serializer that is still busy
            S_LOAD:      if (i_ready) next_state = S_GO;
            S_GO:        next_state = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!i_ready)     next_state = S_WAIT_DONE;
                else if (busy_hit) next_state = S_CHECK;
            end
            S_WAIT_DONE: if (i_ready) next_state = S_CHECK;
            S_CHECK: begin
                if (!failed)       next_state = S_NEXT;
`ifdef CODEC_CFG_RETRY_EN
                else if (retry_ok) next_state = S_LOAD;
                else               next_state = S_ERROR;
`else
                else               next_state = S_NEXT;
`endif
            end
            S_NEXT:      next_state = last ? S_DONE : S_LOAD;
            S_DONE,
            S_ERROR:     if (i_start) next_state = S_LOAD;
            default:     next_state = S_DELAY;
        endcase
    end

    always_comb begin
        o_go   = (state == S_GO);
        o_busy = !((state == S_DONE) || (state == S_ERROR));
        o_done = (state == S_DONE);
`ifdef CODEC_CFG_RETRY_EN
        o_error = (state == S_ERROR);
`else
        o_error = (state == S_DONE) && (err_count != 8'd0);
`endif
    end

    assign o_index     = idx;
    assign o_err_count = err_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_cnt   <= 16'd0;
            to_cnt    <= 8'd0;
            retry     <= 8'd0;
            idx       <= 4'd0;
            err_count <= 8'd0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            o_data    <= 24'd0;
        end else begin
            case (state)
                S_DELAY: if (!delay_hit) dly_cnt <= dly_cnt + 16'd1;
                S_LOAD:  o_data <= {DEV_ADDR, table_entry(idx)};
                S_GO: begin
                    to_cnt    <= 8'd0;
                    ack_q     <= 1'b0;
                    timeout_q <= 1'b0;
                end
                S_WAIT_BUSY: begin
                    if (i_ready) begin
                        to_cnt <= to_cnt + 8'd1;
                        if (busy_hit) timeout_q <= 1'b1;
                    end
                end
                S_WAIT_DONE: if (i_ready) ack_q <= i_ack;
                S_CHECK: begin
                    if (failed) begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        // without retry this only tracks attempts on the current entry
                        if (retry_ok) retry <= retry + 8'd1;
                    end
                end
                S_NEXT: begin
                    retry <= 8'd0;
                    if (!last) idx <= idx + 4'd1;
                end
                S_DONE, S_ERROR: begin
                    if (i_start) begin
                        idx       <= 4'd0;
                        retry     <= 8'd0;
                        err_count <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: a serializer model feeds a go-pulse scoreboard, plus table-driven end-state checks.
`timescale 1ns/1ps
module tb_codec_cfg_sequencer;
    localparam int LUT     = 10;
    localparam int MAXR    = 3;
    localparam int LOW_CYC = 33;
`ifdef CODEC_CFG_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_ready = 1'b1;
    logic        i_ack = 1'b0;
    logic        o_go;
    logic [23:0] o_data;
    logic        o_busy, o_done, o_error;
    logic [3:0]  o_index;
    logic [7:0]  o_err_count;

    int checks = 0;
    int errors = 0;
    int gos = 0;

    int nack_idx = 15;
    int nack_times = 0;
    bit stuck = 1'b0;
    bit hold_busy = 1'b0;
    int ser_cnt = 0;
    int nack_given = 0;
    bit pend = 1'b0;

    logic [27:0] obs[$];
    logic [27:0] exp_q[$];
    logic [15:0] tbl[LUT];

    typedef struct {
        string name;
        int    nidx;
        int    ntimes;
        bit    stk;
        bit    done;
        bit    err;
        int    idx;
        int    errc;
        int    ngo;
    } vec_t;
    vec_t vec[4];

    always #5 clk = ~clk;

    codec_cfg_sequencer #(.START_DELAY(16'd8)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .o_go(o_go), .o_data(o_data),
        .i_ready(i_ready), .i_ack(i_ack), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_index(o_index), .o_err_count(o_err_count)
    );

    // serializer model: busy LOW_CYC cycles per go, NACKs entry nack_idx nack_times times
    always @(negedge clk) begin
        if (!reset) begin
            ser_cnt    = 0;
            nack_given = 0;
            i_ready    = !hold_busy;
            i_ack      = 1'b0;
        end else if (ser_cnt != 0) begin
            ser_cnt = ser_cnt - 1;
            if (ser_cnt == 0) begin
                i_ready = 1'b1;
                i_ack   = pend;
            end
        end else begin
            i_ready = !hold_busy;
            if (o_go) begin
                obs.push_back({o_index, o_data});
                if (!stuck) begin
                    pend = (int'(o_index) == nack_idx) && (nack_given < nack_times);
                    if (pend) nack_given = nack_given + 1;
                    i_ready = 1'b0;
                    ser_cnt = LOW_CYC;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input int ni, input int nt, input bit s,
                                input bit d, input bit e, input int ix, input int ec, input int ng);
        vec_t v;
        v.name = n; v.nidx = ni; v.ntimes = nt; v.stk = s;
        v.done = d; v.err = e; v.idx = ix; v.errc = ec; v.ngo = ng;
        return v;
    endfunction

    // expected go sequence for the current model configuration
    task automatic build_exp();
        int  fails;
        bit  stop;
        exp_q.delete();
        stop = 1'b0;
        for (int i = 0; i < LUT && !stop; i++) begin
            fails = 0;
            forever begin
                exp_q.push_back({4'(i), 8'h34, tbl[i]});
                if (!(stuck || (i == nack_idx && fails < nack_times))) break;
                fails++;
                if (!RETRY) break;
                if (fails > MAXR) begin
                    stop = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic drain();
        logic [27:0] o;
        while (obs.size() != 0) begin
            o = obs.pop_front();
            gos++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL go_extra got %0h exp none", o);
            end else begin
                chk("go_data", 32'(o), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (o_busy && n < 5000) begin
            @(negedge clk);
            drain();
            n++;
        end
        chk({name, "_finished"}, 32'(o_busy), 32'd0);
        repeat (80) begin
            @(negedge clk);
            drain();
        end
        chk({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic start_run();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        obs.delete();
        gos = 0;
        build_exp();
        reset = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_go"},    32'(o_go), 32'd0);
        chk({tag, "_data"},  32'(o_data), 32'd0);
        chk({tag, "_busy"},  32'(o_busy), 32'd1);
        chk({tag, "_done"},  32'(o_done), 32'd0);
        chk({tag, "_error"}, 32'(o_error), 32'd0);
        chk({tag, "_index"}, 32'(o_index), 32'd0);
        chk({tag, "_errc"},  32'(o_err_count), 32'd0);
    endtask

    task automatic wait_go(input string name, input int lo, input int hi);
        int n;
        n = 0;
        while (!o_go && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < lo || n > hi) begin
            errors++;
            $display("FAIL %s got %0d cycles exp %0d..%0d", name, n, lo, hi);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    initial begin
        tbl[0] = 16'h001A; tbl[1] = 16'h021A; tbl[2] = 16'h047B; tbl[3] = 16'h067B;
        tbl[4] = 16'h08F8; tbl[5] = 16'h0A06; tbl[6] = 16'h0C00; tbl[7] = 16'h0E01;
        tbl[8] = 16'h1002; tbl[9] = 16'h1201;
`ifdef CODEC_CFG_RETRY_EN
        vec[0] = mk("all_ack",     15, 0,    1'b0, 1'b1, 1'b0, 9, 0, 10);
        vec[1] = mk("nack4_once",  4,  1,    1'b0, 1'b1, 1'b0, 9, 1, 11);
        vec[2] = mk("nack2_ever",  2,  1000, 1'b0, 1'b0, 1'b1, 2, 4, 6);
        vec[3] = mk("never_busy",  15, 0,    1'b1, 1'b0, 1'b1, 0, 4, 4);
`else
        vec[0] = mk("all_ack",     15, 0,    1'b0, 1'b1, 1'b0, 9, 0, 10);
        vec[1] = mk("nack4_once",  4,  1,    1'b0, 1'b1, 1'b1, 9, 1, 10);
        vec[2] = mk("nack2_ever",  2,  1000, 1'b0, 1'b1, 1'b1, 9, 1, 10);
        vec[3] = mk("never_busy",  15, 0,    1'b1, 1'b1, 1'b1, 9, 10, 10);
`endif

        // reset values and start-up latency
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        nack_idx = 15; nack_times = 0; stuck = 1'b0;
        obs.delete(); gos = 0; build_exp();
        reset = 1'b1;
        wait_go("first_go_latency", 8, 10);
        wait_end("startup");
        chk("startup_done", 32'(o_done), 32'd1);

        for (int v = 0; v < 4; v++) begin
            nack_idx = vec[v].nidx; nack_times = vec[v].ntimes; stuck = vec[v].stk;
            start_run();
            wait_end(vec[v].name);
            chk({vec[v].name, "_done"},  32'(o_done), 32'(vec[v].done));
            chk({vec[v].name, "_error"}, 32'(o_error), 32'(vec[v].err));
            chk({vec[v].name, "_index"}, 32'(o_index), 32'(vec[v].idx));
            chk({vec[v].name, "_errc"},  32'(o_err_count), 32'(vec[v].errc));
            chk({vec[v].name, "_gos"},   32'(gos), 32'(vec[v].ngo));
        end

        // reset while entry 5 is in flight
        nack_idx = 15; nack_times = 0; stuck = 1'b0;
        start_run();
        begin
            int n;
            n = 0;
            while (gos < 6 && n < 3000) begin
                @(negedge clk);
                drain();
                n++;
            end
        end
        chk("mid_reach5", 32'(gos), 32'd6);
        repeat (5) @(negedge clk);
        chk("mid_index", 32'(o_index), 32'd5);
        #2 reset = 1'b0;
        #1 chk_reset_vals("mid_rst");
        start_run();
        wait_go("restart_latency", 8, 10);
        wait_end("mid_restart");
        chk("mid_done", 32'(o_done), 32'd1);
        chk("mid_gos",  32'(gos), 32'd10);

        // i_start from DONE re-runs the table without the settle period
        nack_idx = 4; nack_times = 1;
        start_run();
        wait_end("pre_start");
        chk("pre_start_errc", 32'(o_err_count), 32'd1);
        nack_idx = 15;
        gos = 0; build_exp();
        pulse_start();
        chk("start_done_drop", 32'(o_done), 32'd0);
        chk("start_errc_clr",  32'(o_err_count), 32'd0);
        chk("start_busy",      32'(o_busy), 32'd1);
        wait_go("start_latency", 1, 3);
        wait_end("rerun");
        chk("rerun_done",  32'(o_done), 32'd1);
        chk("rerun_error", 32'(o_error), 32'd0);
        chk("rerun_gos",   32'(gos), 32'd10);

        // LOAD holds off while the serializer reports busy
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        gos = 0; build_exp();
        pulse_start();
        repeat (10) begin
            @(negedge clk);
            drain();
        end
        chk("stall_no_go", 32'(gos), 32'd0);
        chk("stall_busy",  32'(o_busy), 32'd1);
        hold_busy = 1'b0;
        wait_end("stall");
        chk("stall_done", 32'(o_done), 32'd1);
        chk("stall_gos",  32'(gos), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
- Upstream command source for the 24-bit two-wire codec-configuration serializer.
- After reset, waits a power-up settle period, then walks an internal register table.
- For each entry it presents {DEV_ADDR, reg/data word}, pulses go, waits for the serializer's ready handshake, and checks the ACK flag.
- Reports progress, completion and error status to the system.

Parameters:
- DEV_ADDR, 8'h34, codec device address with write bit, sent as o_data[23:16].
- LUT_SIZE, 10, number of table entries (1..16).
- START_DELAY, 16'd2000, clk cycles idle after reset release before the first transfer.
- BUSY_TIMEOUT, 4, cycles allowed for i_ready to drop after o_go.
- MAX_RETRY, 3, retry attempts per entry on NACK or timeout.

Ports:
- clk  in  1  same clock as the serializer.
- reset  in  1  asynchronous, active-low.
- i_start  in  1  one-cycle pulse; re-runs the whole table when in DONE or ERROR (ignored otherwise).
- o_go  out  1  one-cycle start pulse to the serializer.
- o_data  out  24  {DEV_ADDR, table[idx]}, held stable from LOAD through WAIT_DONE.
- i_ready  in  1  serializer idle flag; high = idle, low = transfer in progress.
- i_ack  in  1  serializer ACK flag; 0 = acknowledged, sampled when i_ready rises.
- o_busy  out  1  high in every state except DONE and ERROR.
- o_done  out  1  high in DONE.
- o_error  out  1  high in ERROR.
- o_index  out  4  current table index.
- o_err_count  out  8  total failed attempts, saturating at 255.

Behaviour:
- Reset (async, reset=0) forces state DELAY with delay counter 0, idx 0, retry 0 and err_count 0.
- Output reset values: o_go=0, o_data=0, o_busy=1, o_done=0, o_error=0, o_index=0, o_err_count=0.
- Table (16-bit reg/data), entries 0..9: 16'h001A, 16'h021A, 16'h047B, 16'h067B, 16'h08F8, 16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201. Entries at or above LUT_SIZE are never issued.
- DELAY: counter increments each clk; when it reaches START_DELAY-1, go to LOAD.
- LOAD: o_data <= {DEV_ADDR, table[idx]}; next cycle go to GO.
- GO: o_go=1 for exactly one cycle; go to WAIT_BUSY with timeout counter cleared.
- WAIT_BUSY:
  - i_ready=0 → WAIT_DONE.
  - Otherwise the counter increments; reaching BUSY_TIMEOUT counts as a failed attempt.
- WAIT_DONE: waits indefinitely for i_ready=1; in that cycle latch i_ack and go to CHECK.
- CHECK:
  - Latched ack=0 → NEXT.
  - Latched ack=1 or timeout → err_count+1 (saturating), then:
    - retry<MAX_RETRY: retry+1, back to LOAD (same idx).
    - Otherwise → ERROR.
- NEXT:
  - retry cleared.
  - idx==LUT_SIZE-1 → DONE.
  - Otherwise idx+1 → LOAD.
- DONE / ERROR: terminal, outputs held. i_start clears idx, retry and err_count, then goes to LOAD (no start delay).
- Latency: GO to next LOAD, successful entry, is 2 cycles after i_ready rises (CHECK, NEXT).
- i_ready already 0 in GO (serializer not idle): WAIT_BUSY sees 0 immediately; this is legal.
- Reset mid-transfer: sequencer returns to DELAY immediately. The serializer is reset separately; no o_go is issued during DELAY.
- o_go must never assert while i_ready=0 at the LOAD cycle. If this occurs, LOAD stalls until i_ready=1.

Optional Feature:
- Macro: CODEC_CFG_RETRY_EN.
- Defined: retry behaviour as above.
- Undefined:
  - MAX_RETRY is ignored.
  - A failed attempt increments err_count and proceeds to NEXT (entry skipped).
  - ERROR is unreachable.
  - DONE is reached after LUT_SIZE attempts; o_error instead reports (err_count!=0) while in DONE.

Test Plan:
- START_DELAY=8, model serializer always ACKs (ready low 33 cycles, ack=0) → first o_go 9 cycles (±1) after reset release; 10 go pulses; o_data sequence 24'h34001A … 24'h341201; o_done=1, o_err_count=0.
- Model NACKs entry 4 once → entry 4 issued twice with o_data=24'h3408F8; o_err_count=1; o_done=1.
- Model NACKs entry 2 forever (retry enabled) → 4 attempts at idx 2, o_error=1, o_index=2, o_err_count=4, no further o_go.
- Model never drops i_ready → o_go, 4 cycles wait, timeout counted, retry; ends in ERROR at idx 0 with o_err_count=4.
- Assert reset during WAIT_DONE of entry 5 → all outputs at reset values the same cycle; sequence restarts from idx 0 after START_DELAY.
- From DONE, pulse i_start → o_done drops, o_err_count=0, full 10-entry sequence reissued without start delay.
